// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO holding {pc, inst} pairs; the head is read combinationally from storage.
module ifetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero until the first fetch lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_sequencer.sv
// Fetch PC / FSM / halt detection in front of the prefetch queue.
// Optional perf counters enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_sequencer
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [31:0]       inst_addr,
  input  logic [INST_W-1:0] inst_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        fetch_pc;
  logic [31:0]        pc_nxt;
  logic [31:0]        pc_plus4;
  logic [31:0]        jump_target;
  logic               deq;
  logic               enq;
  logic               room;
  logic               is_halt;
  logic               q_empty;
  logic [CNT_W-1:0]   q_count;
  logic [32+INST_W-1:0] q_head;

  assign pc_plus4    = fetch_pc + 32'd4;
  assign jump_target = {pc_plus4[31:28], inst_data[25:0], 2'b00};
  assign is_halt     = (inst_data[31:26] == OP_J) && (jump_target == fetch_pc);

  assign room = (q_count < CNT_W'(QDEPTH));
  assign deq  = if_valid && if_ready && !redirect_valid;
  assign enq  = (state == FETCH) && !redirect_valid && (room || deq);

  assign inst_addr = fetch_pc;
  assign if_valid  = !q_empty;
  assign if_pc     = q_head[32+INST_W-1:INST_W];
  assign if_inst   = q_head[INST_W-1:0];
  assign halted    = (state == HALT);

  ifetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (32 + INST_W)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (enq),
    .pop     (deq),
    .flush   (redirect_valid),
    .wdata   ({fetch_pc, inst_data}),
    .rdata   (q_head),
    .empty   (q_empty),
    .count   (q_count)
  );

  // Redirect beats everything, and is the only way out of HALT besides reset.
  always_comb begin
    state_nxt = state;
    pc_nxt    = fetch_pc;
    if (redirect_valid) begin
      state_nxt = FETCH;
      pc_nxt    = {redirect_pc[31:2], 2'b00};
    end else if (enq) begin
      pc_nxt = pc_plus4;
      if (is_halt) state_nxt = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign stall = (state == FETCH) && !room && !deq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (enq)   perf_fetched <= sat_inc(perf_fetched);
      if (stall) perf_stall   <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Scoreboard bench for ifetch_sequencer: queue-level reference model plus directed scenarios.
module tb_ifetch_sequencer;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halted;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] rom [256];
  logic [63:0] mq [$];
  logic [63:0] exp_q [$];
  logic [31:0] m_pc;
  bit          m_halt;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          halt_seen = 0;

  always #5 clk = ~clk;
  assign inst_data = rom[inst_addr[9:2]];

  ifetch_sequencer #(
    .RESET_PC (32'h0),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // One modelled clock: drive inputs at negedge, check pre-edge outputs, advance the model.
  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rpc);
    int          sz;
    bit          pop;
    bit          push;
    logic [31:0] ins;
    logic [31:0] nxt;
    @(negedge clk);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    check("inst_addr", inst_addr, m_pc);
    check("if_valid", 32'(if_valid), 32'(mq.size() > 0));
    check("halted", 32'(halted), 32'(m_halt));
    if (rv) begin
      mq.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      sz   = mq.size();
      pop  = (sz > 0) && rdy;
      push = !m_halt && ((sz < QDEPTH) || pop);
      if (pop) exp_q.push_back(mq.pop_front());
      if (push) begin
        ins = rom[m_pc[9:2]];
        nxt = m_pc + 32'd4;
        mq.push_back({m_pc, ins});
        if (ins[31:26] == 6'b000010 && {nxt[31:28], ins[25:0], 2'b00} == m_pc) m_halt = 1'b1;
        m_pc = nxt;
      end
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();
    exp_q.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    #3 reset_n = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head must match the next expected delivery.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && if_valid && if_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL deliver: got pc %h inst %h, required no delivery", if_pc, if_inst);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", if_pc, e[63:32]);
          check("deliver_inst", if_inst, e[31:0]);
          if (if_pc == 32'h1D4 && if_inst == 32'h0800_0075) halt_seen++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] w;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    for (int i = 0; i < 256; i++) begin
      do w = $urandom; while (w[31:26] == 6'b000010);
      rom[i] = w;
    end
    rom[0]    = 32'h2408_0000;
    rom[1]    = 32'h2409_0000;
    rom[5]    = 32'h8dcc_0000;
    rom[8'h75] = 32'h0800_0075;

    // Reset values
    #1;
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);

    // First fetches with decode always ready
    do_reset();
    drive(1, 0, 0);
    after_edge();
    check("first_valid", 32'(if_valid), 32'h1);
    check("first_pc", if_pc, 32'h0);
    check("first_inst", if_inst, 32'h2408_0000);
    drive(1, 0, 0);
    after_edge();
    check("second_pc", if_pc, 32'h4);
    check("second_inst", if_inst, 32'h2409_0000);

    // Backpressure: queue fills and fetch PC holds
    do_reset();
    repeat (5) drive(0, 0, 0);
    after_edge();
    check("bp_inst_addr", inst_addr, 32'h8);
    check("bp_head_pc", if_pc, 32'h0);
    repeat (4) drive(1, 0, 0);

    // Redirect with a full queue while decode is ready
    repeat (3) drive(0, 0, 0);
    drive(1, 1, 32'h14);
    after_edge();
    check("redir_valid_gap", 32'(if_valid), 32'h0);
    drive(1, 0, 0);
    after_edge();
    check("redir_pc", if_pc, 32'h14);
    check("redir_inst", if_inst, 32'h8dcc_0000);
    repeat (2) drive(1, 0, 0);

    // Halt on the terminating self-jump, then resume
    halt_seen = 0;
    drive(1, 1, 32'h1D4);
    repeat (6) drive(1, 0, 0);
    after_edge();
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_inst_addr", inst_addr, 32'h1D8);
    check("halt_valid", 32'(if_valid), 32'h0);
    check("halt_delivered_once", 32'(halt_seen), 32'h1);
    drive(1, 1, 32'h0);
    after_edge();
    check("resume_halted", 32'(halted), 32'h0);
    check("resume_addr", inst_addr, 32'h0);
    drive(1, 0, 0);
    after_edge();
    check("resume_pc", if_pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        1:       rpc = 32'h1D4;
        2:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      drive(rdy, rv, rpc);
    end

    // Reset mid-stream with two queued entries
    drive(0, 1, 32'h40);
    repeat (3) drive(0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(if_valid), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(if_valid), 32'h0);
    check("mid_rst_halted", 32'(halted), 32'h0);
    check("mid_rst_addr", inst_addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    check("mid_rst_perf_fetched", perf_fetched, 32'h0);
    check("mid_rst_perf_stall", perf_stall, 32'h0);
`endif
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
